// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch (IF), load/store (LS) and RAM-side signals of the
// single-port memory arbiter.
//   slave  : the arbiter's view (requests and RAM read data in; grants,
//            responses and RAM controls out)
//   master : the requesters' / RAM's view (the mirror image)
// Signal names keep the _i/_o suffixes as seen from the arbiter.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32
);
  // Fetch requester
  logic                  if_req_i;
  logic [DATA_WIDTH-1:0] if_addr_i;
  logic                  if_flush_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [INST_WIDTH-1:0] if_inst_o;
  logic                  if_err_o;
  // Load/store requester
  logic                  ls_req_i;
  logic                  ls_we_i;
  logic [1:0]            ls_size_i;
  logic [DATA_WIDTH-1:0] ls_addr_i;
  logic [DATA_WIDTH-1:0] ls_wdata_i;
  logic                  ls_gnt_o;
  logic                  ls_rvalid_o;
  logic [DATA_WIDTH-1:0] ls_rdata_o;
  logic                  ls_err_o;
  // Single-port RAM
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [7:0]            mem_be_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_gnt_o, if_rvalid_o, if_inst_o, if_err_o,
    input  ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_gnt_o, if_rvalid_o, if_inst_o, if_err_o,
    output ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates one synchronous single-port RAM (1-cycle read latency) between
// instruction fetch (IF) and load/store (LS). One access per cycle, LS wins
// unless IF has been denied STARVE_LIMIT consecutive cycles. Grants and RAM
// controls are combinational; responses are presented one cycle after the
// grant from a registered owner/offset/size record.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset (also suppresses grants/responses)
//   bus    mem_port_arbiter_if.slave: IF, LS and RAM signal groups
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int INST_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_RESP = 2'd1,
    LS_RESP = 2'd2
  } state_e;

  function automatic logic ls_misaligned(input logic [2:0] a, input logic [1:0] size);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = a[0];
      2'd2:    mis = |a[1:0];
      default: mis = |a;
    endcase
    return mis;
  endfunction

  function automatic logic [7:0] ls_byte_en(input logic [2:0] a, input logic [1:0] size);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] size);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    case (size)
      2'd0:    m[7:0]  = '1;
      2'd1:    m[15:0] = '1;
      2'd2:    m[31:0] = '1;
      default: m       = '1;
    endcase
    return m;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic        flush_q, flush_d;

  logic                  if_mis, ls_mis, starve;
  logic                  gnt_if, gnt_ls;
  logic                  mem_en, mem_we;
  logic [DATA_WIDTH-1:0] mem_addr, mem_wdata;
  logic [7:0]            mem_be;

  // Arbitration, RAM request and next-state record
  always_comb begin
    if_mis    = |bus.if_addr_i[1:0];
    ls_mis    = ls_misaligned(bus.ls_addr_i[2:0], bus.ls_size_i);
    starve    = (cnt_q == LIMIT) & bus.if_req_i;
    gnt_if    = !rst_i & bus.if_req_i & (!bus.ls_req_i | starve);
    gnt_ls    = !rst_i & bus.ls_req_i & !gnt_if;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;

    state_d   = IDLE;
    off_d     = '0;
    size_d    = '0;
    err_d     = 1'b0;
    we_d      = 1'b0;
    flush_d   = 1'b0;

    // A misaligned request is still granted so the requester can move on;
    // it just never reaches the RAM and returns an error response.
    if (gnt_if) begin
      state_d = IF_RESP;
      off_d   = bus.if_addr_i[2:0];
      size_d  = 2'd2;
      err_d   = if_mis;
      flush_d = bus.if_flush_i;
      if (!if_mis) begin
        mem_en   = 1'b1;
        mem_addr = {bus.if_addr_i[DATA_WIDTH-1:3], 3'b000};
        mem_be   = 8'h0F << bus.if_addr_i[2:0];
      end
    end else if (gnt_ls) begin
      state_d = LS_RESP;
      off_d   = bus.ls_addr_i[2:0];
      size_d  = bus.ls_size_i;
      err_d   = ls_mis;
      we_d    = bus.ls_we_i;
      if (!ls_mis) begin
        mem_en    = 1'b1;
        mem_we    = bus.ls_we_i;
        mem_addr  = {bus.ls_addr_i[DATA_WIDTH-1:3], 3'b000};
        mem_be    = ls_byte_en(bus.ls_addr_i[2:0], bus.ls_size_i);
        mem_wdata = bus.ls_wdata_i << {bus.ls_addr_i[2:0], 3'b000};
      end
    end

    // Counts consecutive cycles IF waits; forced win once it hits LIMIT.
    if (!bus.if_req_i || gnt_if) begin
      cnt_d = '0;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Response record register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      size_q  <= size_d;
      err_q   <= err_d;
      we_q    <= we_d;
      flush_q <= flush_d;
    end
  end

  logic                  if_rvalid, if_err, ls_rvalid, ls_err;
  logic [INST_WIDTH-1:0] if_inst;
  logic [DATA_WIDTH-1:0] ls_rdata;

  // Response stage: RAM read data arrives now, one cycle after the grant.
  // A response due while rst_i is high is dropped.
  always_comb begin
    if_rvalid = 1'b0;
    if_err    = 1'b0;
    if_inst   = '0;
    ls_rvalid = 1'b0;
    ls_err    = 1'b0;
    ls_rdata  = '0;
    if (!rst_i) begin
      case (state_q)
        IF_RESP: begin
          // Flush either at grant time or now kills the fetch.
          if (!flush_q && !bus.if_flush_i) begin
            if_rvalid = 1'b1;
            if_err    = err_q;
            if (!err_q) begin
              if_inst = off_q[2] ? bus.mem_rdata_i[2*INST_WIDTH-1:INST_WIDTH]
                                 : bus.mem_rdata_i[INST_WIDTH-1:0];
            end
          end
        end
        LS_RESP: begin
          ls_rvalid = 1'b1;
          ls_err    = err_q;
          if (!err_q && !we_q) begin
            ls_rdata = (bus.mem_rdata_i >> {off_q, 3'b000}) & size_mask(size_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.if_gnt_o    = gnt_if;
  assign bus.ls_gnt_o    = gnt_ls;
  assign bus.mem_en_o    = mem_en;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_be_o    = mem_be;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.if_rvalid_o = if_rvalid;
  assign bus.if_err_o    = if_err;
  assign bus.if_inst_o   = if_inst;
  assign bus.ls_rvalid_o = ls_rvalid;
  assign bus.ls_err_o    = ls_err;
  assign bus.ls_rdata_o  = ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int DW    = 64;
  localparam int IW    = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW)) bus ();

  mem_port_arbiter #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] init_word(input int i);
    if (i == 0) return 64'h1111_2222_3333_4444;
    return {32'(i) * 32'h9E37_79B1, (32'(i) * 32'h7F4A_7C15) ^ 32'hA5A5_A5A5};
  endfunction

  // RAM behaviour: 64 words, 1-cycle read latency, byte-enabled writes
  logic [63:0] ram [64];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      bus.mem_rdata_i <= '0;
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < 8; b++)
          if (bus.mem_be_o[b]) ram[bus.mem_addr_o[8:3]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end else begin
        bus.mem_rdata_i <= ram[bus.mem_addr_o[8:3]];
      end
    end
  end

  typedef struct {
    logic [63:0] addr;
    bit          we;
    logic [1:0]  size;
    logic [63:0] wdata;
    int          fl;   // 0 none, 1 flush while requesting, 2 flush in response cycle
  } req_t;

  typedef struct {
    int          due;
    bit          fl;
    logic [63:0] data;
    bit          err;
  } exp_t;

  req_t if_todo[$], ls_todo[$];
  exp_t ifq[$], lsq[$];
  logic [63:0] ref_mem [64];
  bit if_busy = 0, ls_busy = 0, flush_next = 0, rnd_flush = 0;

  // Stimulus driver: issues requests, and on acceptance pushes the expected
  // response computed from the reference memory.
  initial begin
    req_t if_cur, ls_cur;
    exp_t e;
    logic [63:0] w, wsh, mask;
    logic [7:0] ebe;
    logic [2:0] off;
    bit mis;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    bus.if_req_i = 0; bus.if_addr_i = '0; bus.if_flush_i = 0;
    bus.ls_req_i = 0; bus.ls_we_i = 0; bus.ls_size_i = '0;
    bus.ls_addr_i = '0; bus.ls_wdata_i = '0;
    forever begin
      @(negedge clk);
      if (bus.if_gnt_o && if_busy) begin
        off = if_cur.addr[2:0];
        mis = (if_cur.addr % 4) != 0;
        w = ref_mem[if_cur.addr[8:3]] >> (8 * off);
        e.due = cyc + 1; e.fl = bus.if_flush_i; e.err = mis;
        e.data = mis ? 64'h0 : {32'h0, w[31:0]};
        ifq.push_back(e);
        if (mis) check("if_mis_mem_en", bus.mem_en_o, 1'b0);
        else check("if_mem", {bus.mem_en_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o},
                   {1'b1, 1'b0, 8'(8'h0F << off), if_cur.addr & ~64'h7});
        if (if_cur.fl == 2) flush_next = 1;
        if_busy = 0;
      end else if (bus.ls_gnt_o && ls_busy) begin
        off = ls_cur.addr[2:0];
        mis = (ls_cur.addr % (64'd1 << ls_cur.size)) != 0;
        ebe = 8'((16'd1 << (1 << ls_cur.size)) - 16'd1) << off;
        wsh = ls_cur.wdata << (8 * off);
        mask = (ls_cur.size == 2'd3) ? '1 : ((64'd1 << (8 << ls_cur.size)) - 64'd1);
        e.due = cyc + 1; e.fl = 0; e.err = mis; e.data = '0;
        if (mis) begin
          check("ls_mis_mem_en", bus.mem_en_o, 1'b0);
        end else begin
          check("ls_mem", {bus.mem_en_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o},
                {1'b1, ls_cur.we, ebe, ls_cur.addr & ~64'h7});
          if (ls_cur.we) begin
            check("ls_wdata", bus.mem_wdata_o, wsh);
            for (int b = 0; b < 8; b++)
              if (ebe[b]) ref_mem[ls_cur.addr[8:3]][8*b +: 8] = wsh[8*b +: 8];
          end else begin
            e.data = (ref_mem[ls_cur.addr[8:3]] >> (8 * off)) & mask;
          end
        end
        lsq.push_back(e);
        ls_busy = 0;
      end else if (!bus.if_gnt_o && !bus.ls_gnt_o) begin
        check("idle_mem", {bus.mem_en_o, bus.mem_we_o, bus.mem_be_o}, 10'h0);
      end
      @(posedge clk); #1;
      if (!if_busy && if_todo.size() > 0) begin if_cur = if_todo.pop_front(); if_busy = 1; end
      if (!ls_busy && ls_todo.size() > 0) begin ls_cur = ls_todo.pop_front(); ls_busy = 1; end
      bus.if_req_i   = if_busy;
      bus.if_addr_i  = if_cur.addr;
      bus.if_flush_i = (if_busy && if_cur.fl == 1) || flush_next ||
                       (rnd_flush && $urandom_range(0, 9) == 0);
      flush_next     = 0;
      bus.ls_req_i   = ls_busy;
      bus.ls_we_i    = ls_cur.we;
      bus.ls_size_i  = ls_cur.size;
      bus.ls_addr_i  = ls_cur.addr;
      bus.ls_wdata_i = ls_cur.wdata;
    end
  end

  // Monitor: arbitration rule each cycle, and pops/compares responses as
  // they fall due.
  initial begin
    int ifwait = 0;
    bit eif, els, ev;
    exp_t e;
    forever begin
      @(negedge clk);
      eif = !rst && bus.if_req_i && (!bus.ls_req_i || ifwait == LIMIT);
      els = !rst && bus.ls_req_i && !eif;
      check("grant", {bus.if_gnt_o, bus.ls_gnt_o}, {eif, els});
      if (rst || !bus.if_req_i || eif) ifwait = 0;
      else if (ifwait < LIMIT) ifwait++;

      if (ifq.size() > 0 && ifq[0].due == cyc) begin
        e = ifq.pop_front();
        ev = !rst && !(e.fl || bus.if_flush_i);
        check("if_rvalid", bus.if_rvalid_o, ev);
        if (ev) check("if_resp", {bus.if_err_o, bus.if_inst_o}, {e.err, e.data[31:0]});
      end else begin
        check("if_quiet", {bus.if_rvalid_o, bus.if_err_o, bus.if_inst_o}, 34'h0);
      end

      if (lsq.size() > 0 && lsq[0].due == cyc) begin
        e = lsq.pop_front();
        if (rst) check("ls_rst_drop", bus.ls_rvalid_o, 1'b0);
        else check("ls_resp", {bus.ls_rvalid_o, bus.ls_err_o, bus.ls_rdata_o}, {1'b1, e.err, e.data});
      end else begin
        check("ls_quiet", {bus.ls_rvalid_o, bus.ls_err_o, bus.ls_rdata_o}, 66'h0);
      end
    end
  end

  function automatic req_t mk(input logic [63:0] a, input bit we, input logic [1:0] sz,
                              input logic [63:0] wd, input int fl);
    req_t r;
    r.addr = a; r.we = we; r.size = sz; r.wdata = wd; r.fl = fl;
    return r;
  endfunction

  function automatic req_t rnd_if();
    logic [63:0] a;
    a = 64'($urandom_range(0, 511));
    if ($urandom_range(0, 4) != 0) a = a & ~64'h3;
    return mk(a, 0, 2'd2, '0, 0);
  endfunction

  function automatic req_t rnd_ls(input bit allow_store);
    logic [63:0] a;
    logic [1:0] sz;
    sz = 2'($urandom_range(0, 3));
    a = 64'($urandom_range(0, 511));
    if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
    return mk(a, allow_store && $urandom_range(0, 1) == 1, sz, {$urandom, $urandom}, 0);
  endfunction

  task automatic drain();
    int t = 0;
    while ((if_todo.size() > 0 || ls_todo.size() > 0 || if_busy || ls_busy ||
            ifq.size() > 0 || lsq.size() > 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d cycles expected < 3000", t);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 0; preload = 0;

    // Sequential fetches from word 0
    if_todo.push_back(mk(64'h0, 0, 2'd2, '0, 0));
    if_todo.push_back(mk(64'h4, 0, 2'd2, '0, 0));
    if_todo.push_back(mk(64'h8, 0, 2'd2, '0, 0));
    drain();

    // Continuous contention: LS x4 then IF, repeating
    for (int i = 0; i < 12; i++) begin
      if_todo.push_back(mk(64'($urandom_range(0, 127)) << 2, 0, 2'd2, '0, 0));
      ls_todo.push_back(mk(64'($urandom_range(0, 63)) << 3, 0, 2'd3, '0, 0));
    end
    drain();

    // Half store/load at 0x106, misaligned word load
    ls_todo.push_back(mk(64'h106, 1, 2'd1, 64'hBEEF, 0));
    ls_todo.push_back(mk(64'h106, 0, 2'd1, '0, 0));
    ls_todo.push_back(mk(64'h102, 0, 2'd2, '0, 0));
    drain();

    // Flushed fetches: flush at grant, flush in response cycle
    if_todo.push_back(mk(64'h20, 0, 2'd2, '0, 1));
    if_todo.push_back(mk(64'h20, 0, 2'd2, '0, 2));
    if_todo.push_back(mk(64'h24, 0, 2'd2, '0, 0));
    drain();

    // Reset the cycle after an LS read grant
    ls_todo.push_back(mk(64'h40, 0, 2'd3, '0, 0));
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.ls_gnt_o && t < 100);
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL ls_grant_timeout: got %0d cycles expected < 100", t);
    end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 6; i++) begin
      if_todo.push_back(rnd_if());
      ls_todo.push_back(rnd_ls(0));
    end
    drain();

    // Randomized mixed traffic with random flushes
    rnd_flush = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) if_todo.push_back(rnd_if());
      else ls_todo.push_back(rnd_ls(1));
    end
    drain();
    rnd_flush = 0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Single-port memory arbiter and sequencer between the instruction-fetch requester (IF) and the load/store requester (LS, MEM stage).
- Drives one synchronous single-port RAM with 1-cycle read latency.
- Issues at most one access per cycle; LS has priority, with a starvation guard for IF.
- Generates byte enables, aligns store data, extracts fetch/load data, flags misalignment, and returns tagged responses one cycle after grant.

Parameters:
DATA_WIDTH, 64, RAM word and LS data width
INST_WIDTH, 32, fetch data width
STARVE_LIMIT, 4, consecutive denied IF cycles before IF is forced to win (1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
if_req_i  in  1  fetch request, held until granted
if_addr_i  in  DATA_WIDTH  fetch byte address
if_flush_i  in  1  kill fetch response due next cycle (prediction failed)
if_gnt_o  out  1  fetch accepted this cycle (combinational)
if_rvalid_o  out  1  fetch response valid
if_inst_o  out  INST_WIDTH  fetched instruction
if_err_o  out  1  fetch misaligned, qualified by if_rvalid_o
ls_req_i  in  1  load/store request, held until granted
ls_we_i  in  1  1 = store
ls_size_i  in  2  0 byte, 1 half, 2 word, 3 dword
ls_addr_i  in  DATA_WIDTH  byte address
ls_wdata_i  in  DATA_WIDTH  store data, LSB-justified
ls_gnt_o  out  1  LS accepted this cycle (combinational)
ls_rvalid_o  out  1  LS response (load data or store ack)
ls_rdata_o  out  DATA_WIDTH  load data, shifted down, zero-extended to size
ls_err_o  out  1  LS misaligned, qualified by ls_rvalid_o
mem_en_o  out  1  RAM enable
mem_we_o  out  1  RAM write
mem_addr_o  out  DATA_WIDTH  RAM address, bits [2:0] forced to 0
mem_be_o  out  8  byte enables
mem_wdata_o  out  DATA_WIDTH  aligned store data
mem_rdata_i  in  DATA_WIDTH  RAM read word, valid cycle after read enable

Behaviour:
- All decisions and RAM outputs are combinational from requests and state. Responses come from registers.
- Arbitration:
  - starve = (cnt == STARVE_LIMIT) & if_req_i.
  - Grant IF if if_req_i & (!ls_req_i | starve); otherwise grant LS if ls_req_i.
  - Never grant both in one cycle.
- Starvation counter cnt (4 bits):
  - Resets to 0 when IF is granted or if_req_i = 0.
  - Increments while IF is denied; saturates at STARVE_LIMIT.
- Misalignment:
  - IF: if_addr_i[1:0] != 0.
  - LS: addr not a multiple of 2^size.
  - A misaligned request is still granted but mem_en_o = 0 that cycle; the response carries err = 1 with data = 0.
- Aligned grant:
  - mem_en_o = 1; mem_addr_o = {addr[63:3], 3'b0}; mem_we_o = ls_we_i only for an LS grant.
  - Byte enables: mem_be_o = ((1 << 2^size) - 1) << addr[2:0]; IF uses 0x0F << addr[2:0].
  - Store data: mem_wdata_o = ls_wdata_i << 8*addr[2:0].
- No grant: mem_en_o = 0, mem_we_o = 0, mem_be_o = 0.
- Response FSM (registered owner), states:
  - IDLE: no response due.
  - IF_RESP: fetch response due.
  - LS_RESP: LS response due.
- FSM next state:
  - IF grant → IF_RESP; LS grant → LS_RESP; otherwise IDLE.
  - A new grant is allowed in any state (fully pipelined, 1 access/cycle).
  - Stored with owner: offset addr[2:0], size, err, we.
- IF_RESP:
  - if_rvalid_o = !flush_seen, where flush_seen is if_flush_i registered at the grant cycle OR if_flush_i in the response cycle.
  - if_inst_o = mem_rdata_i[32*offset[2] +: 32].
- LS_RESP:
  - ls_rvalid_o = 1.
  - Load: ls_rdata_o = (mem_rdata_i >> 8*offset) masked to size.
  - Store: ack only, rdata = 0.
- Outputs not in their response state are 0.
- Reset: state = IDLE, cnt = 0, all registered fields 0. Next cycle all rvalid/err outputs are 0; a pending response is discarded. Grants are suppressed while rst_i = 1.

Test Plan:
- IF-only stream at addresses 0x0, 0x4, 0x8 with RAM word@0 = 0x1111_2222_3333_4444 → if_gnt_o every cycle; if_inst_o = 0x33334444, then 0x11112222, each one cycle after grant.
- IF and LS both requesting continuously, STARVE_LIMIT = 4 → LS granted 4 cycles, IF granted on the 5th, counter returns to 0, pattern repeats.
- Store half 0xBEEF at 0x106 → mem_be_o = 0xC0, mem_wdata_o[63:48] = 0xBEEF. Then load half at 0x106 → ls_rdata_o = 0xBEEF, ls_err_o = 0.
- Load word at 0x102 → no RAM enable; next cycle ls_rvalid_o = 1, ls_err_o = 1, ls_rdata_o = 0.
- IF granted at 0x20 with if_flush_i = 1 the same or next cycle → if_rvalid_o stays 0.
- rst_i asserted the cycle after an LS read grant → no ls_rvalid_o, state IDLE, cnt = 0.
